// File: rtl/seg_rw_arb.sv
// Two-requester read/write arbiter in front of a single-port segment memory.
// Define SEG_RW_ARB_RR_EN for round-robin arbitration; the default is fixed priority (requester 0 wins).
module seg_rw_arb #(
  parameter int AWIDTH = 7,
  parameter int DWIDTH = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [AWIDTH-1:0] req_addr0,
  input  logic [AWIDTH-1:0] req_addr1,
  input  logic [DWIDTH-1:0] req_wdata0,
  input  logic [DWIDTH-1:0] req_wdata1,
  input  logic [1:0]        req_write,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DWIDTH-1:0] rsp_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, RDWAIT, RESP} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_grant;
  logic              r_last_grant;
  logic [1:0]        r_rsp_valid;
  logic [DWIDTH-1:0] r_rsp_data;
  logic              w_gnt;
  logic              w_accept;

  // With nothing valid the index parks on the last winner; it is unused then.
  always_comb begin
`ifdef SEG_RW_ARB_RR_EN
    if (req_valid == 2'b11)  w_gnt = ~r_last_grant;
    else if (req_valid[0])   w_gnt = 1'b0;
    else if (req_valid[1])   w_gnt = 1'b1;
    else                     w_gnt = r_last_grant;
`else
    if (req_valid[0])        w_gnt = 1'b0;
    else if (req_valid[1])   w_gnt = 1'b1;
    else                     w_gnt = r_last_grant;
`endif
  end

  // Reset also gates the combinational accept so nothing is granted while held.
  assign w_accept = reset && (r_state == IDLE) && (req_valid != 2'b00);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept && !req_write[w_gnt]) w_next = RDWAIT;
      RDWAIT:  w_next = RESP;
      RESP:    if (rsp_ready[r_grant]) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 2'b00;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_accept) begin
      req_ready[w_gnt] = 1'b1;
      mem_en           = 1'b1;
      mem_we           = req_write[w_gnt];
      mem_addr         = w_gnt ? req_addr1  : req_addr0;
      mem_wdata        = w_gnt ? req_wdata1 : req_wdata0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rsp_valid  <= 2'b00;
      r_rsp_data   <= '0;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_last_grant <= w_gnt;
        if (!req_write[w_gnt]) r_grant <= w_gnt;
      end
      case (r_state)
        RDWAIT: begin
          r_rsp_data  <= mem_rdata;
          r_rsp_valid <= r_grant ? 2'b10 : 2'b01;
        end
        RESP:    if (rsp_ready[r_grant]) r_rsp_valid <= 2'b00;
        default: ;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_seg_rw_arb.sv
// Scoreboard bench for seg_rw_arb: a behavioural segment memory answers mem_* accesses,
// a shadow copy predicts read data, expected responses are queued at acceptance.
module tb_seg_rw_arb;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_ready, req_write, rsp_valid, rsp_ready;
  logic [6:0]  req_addr0, req_addr1, mem_addr;
  logic [15:0] req_wdata0, req_wdata1, rsp_data, mem_wdata, mem_rdata;
  logic        mem_en, mem_we, busy, mem_clr;

  typedef struct {int idx; logic [15:0] data;} exp_t;
  exp_t        sb[$];
  logic [15:0] sh_mem [128];
  logic [15:0] tb_mem [128];
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 clock = ~clock;

  seg_rw_arb dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr0(req_addr0), .req_addr1(req_addr1), .req_wdata0(req_wdata0),
    .req_wdata1(req_wdata1), .req_write(req_write), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  function automatic logic [15:0] pat(int i);
    return 16'h1000 + 16'(i * 3);
  endfunction

  always @(posedge clock) begin
    if (mem_clr) begin
      for (int i = 0; i < 128; i++) tb_mem[i] <= pat(i);
    end else if (mem_en) begin
      if (mem_we) tb_mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= tb_mem[mem_addr];
    end
  end

  task automatic apply_reset();
    @(negedge clock); reset = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
    @(negedge clock); reset = 1'b1;
  endtask

  task automatic do_read(input int idx, input logic [6:0] addr, input int stall,
                         input logic [1:0] busy_valid, input logic [1:0] stall_rdy);
    logic [1:0] oh;
    exp_t       e;
    oh = (idx == 1) ? 2'b10 : 2'b01;
    @(negedge clock);
    req_valid = oh; req_write = 2'b00;
    req_addr0 = (idx == 0) ? addr : ~addr;
    req_addr1 = (idx == 1) ? addr : ~addr;
    rsp_ready = (stall == 0) ? oh : stall_rdy;
    #2;
    n_cmp++; if (req_ready !== oh) begin n_fail++; $display("FAIL rd_accept: got %b want %b", req_ready, oh); end
    n_cmp++; if ({mem_en, mem_we} !== 2'b10) begin n_fail++; $display("FAIL rd_strobe: got en/we %b want 10", {mem_en, mem_we}); end
    n_cmp++; if (mem_addr !== addr) begin n_fail++; $display("FAIL rd_addr: got %0d want %0d", mem_addr, addr); end
    sb.push_back('{idx, sh_mem[addr]});
    @(negedge clock); req_valid = busy_valid; #2;
    n_cmp++; if ({rsp_valid, req_ready, mem_en, busy} !== 6'b000001) begin
      n_fail++; $display("FAIL rd_wait: got valid/ready/en/busy %b want 000001", {rsp_valid, req_ready, mem_en, busy});
    end
    for (int s = 0; s <= stall; s++) begin
      @(negedge clock); if (s == stall) rsp_ready = oh; #2;
      n_cmp++; if (rsp_valid !== oh) begin n_fail++; $display("FAIL rd_rsp_valid[%0d]: got %b want %b", s, rsp_valid, oh); end
      n_cmp++; if ({req_ready, mem_en, busy} !== 4'b0001) begin
        n_fail++; $display("FAIL rd_rsp_block[%0d]: got ready/en/busy %b want 0001", s, {req_ready, mem_en, busy});
      end
      if (s == stall) begin
        e = sb.pop_front();
        n_cmp++; if (rsp_data !== e.data || rsp_valid !== ((e.idx == 1) ? 2'b10 : 2'b01)) begin
          n_fail++; $display("FAIL rd_data: got %h/%b want %h/req%0d", rsp_data, rsp_valid, e.data, e.idx);
        end
      end else begin
        n_cmp++; if (rsp_data !== sb[0].data) begin n_fail++; $display("FAIL rd_hold_data: got %h want %h", rsp_data, sb[0].data); end
      end
    end
    @(negedge clock); rsp_ready = 2'b00; req_valid = 2'b00; #2;
    n_cmp++; if ({busy, rsp_valid} !== 3'b000) begin n_fail++; $display("FAIL rd_done: got busy/valid %b want 000", {busy, rsp_valid}); end
  endtask

  task automatic test_reset();
    @(negedge clock); reset = 1'b0; req_valid = 2'b11; req_write = 2'b00; mem_clr = 1'b1;
    @(negedge clock); #2;
    n_cmp++; if ({req_ready, mem_en} !== 3'b000) begin n_fail++; $display("FAIL reset_gate: got ready/en %b want 000", {req_ready, mem_en}); end
    n_cmp++; if ({busy, rsp_valid} !== 3'b000) begin n_fail++; $display("FAIL reset_state: got busy/valid %b want 000", {busy, rsp_valid}); end
    n_cmp++; if (rsp_data !== 16'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0000", rsp_data); end
    @(negedge clock); mem_clr = 1'b0; req_valid = 2'b00; reset = 1'b1; #2;
    n_cmp++; if ({req_ready, mem_en} !== 3'b000) begin n_fail++; $display("FAIL idle_novalid: got ready/en %b want 000", {req_ready, mem_en}); end
  endtask

  task automatic test_write();
    @(negedge clock);
    req_valid = 2'b01; req_write = 2'b01; req_addr0 = 7'd5; req_wdata0 = 16'h00AB;
    req_addr1 = 7'd9; req_wdata1 = 16'hDEAD;
    #2;
    n_cmp++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL wr_ready: got %b want 01", req_ready); end
    n_cmp++; if ({mem_en, mem_we} !== 2'b11) begin n_fail++; $display("FAIL wr_strobe: got en/we %b want 11", {mem_en, mem_we}); end
    n_cmp++; if (mem_addr !== 7'd5 || mem_wdata !== 16'h00AB) begin
      n_fail++; $display("FAIL wr_bus: got %0d/%h want 5/00ab", mem_addr, mem_wdata);
    end
    sh_mem[5] = 16'h00AB;
    @(negedge clock); req_valid = 2'b00; #2;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_busy: got %b want 0", busy); end
  endtask

  task automatic test_read();
    do_read(1, 7'd5, 0, 2'b00, 2'b00);
    do_read(0, 7'd77, 2, 2'b00, 2'b10);
  endtask

  task automatic test_arb();
    logic g;
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      req_valid = 2'b11; req_write = 2'b11; req_addr0 = 7'd20; req_addr1 = 7'd30;
      req_wdata0 = 16'hA000 + 16'(c); req_wdata1 = 16'hB000 + 16'(c);
`ifdef SEG_RW_ARB_RR_EN
      g = (c % 2 == 1);
`else
      g = 1'b0;
`endif
      #2;
      n_cmp++; if (req_ready !== (g ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL arb_grant[%0d]: got %b want %b", c, req_ready, g ? 2'b10 : 2'b01); end
      n_cmp++; if (mem_addr !== (g ? 7'd30 : 7'd20) || mem_wdata !== (g ? req_wdata1 : req_wdata0) || busy !== 1'b0) begin
        n_fail++; $display("FAIL arb_bus[%0d]: got %0d/%h busy %b", c, mem_addr, mem_wdata, busy);
      end
      if (g) sh_mem[30] = req_wdata1; else sh_mem[20] = req_wdata0;
    end
    do_read(0, 7'd20, 0, 2'b00, 2'b00);
    do_read(1, 7'd30, 0, 2'b00, 2'b00);
  endtask

  task automatic test_stall();
    do_read(0, 7'd5, 5, 2'b11, 2'b00);
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      req_valid = (c % 2 == 1) ? 2'b10 : 2'b01; req_write = 2'b11;
      req_addr0 = 7'(40 + c); req_addr1 = 7'(40 + c);
      req_wdata0 = 16'hC000 + 16'(c); req_wdata1 = 16'hD000 + 16'(c);
      #2;
      n_cmp++; if (req_ready !== req_valid || mem_en !== 1'b1 || busy !== 1'b0) begin
        n_fail++; $display("FAIL b2b_wr[%0d]: got ready %b en %b busy %b", c, req_ready, mem_en, busy);
      end
      sh_mem[40 + c] = (c % 2 == 1) ? req_wdata1 : req_wdata0;
    end
    do_read(1, 7'd44, 0, 2'b00, 2'b00);
    do_read(0, 7'd41, 0, 2'b00, 2'b00);
  endtask

  task automatic test_reset_in_resp();
    @(negedge clock);
    req_valid = 2'b01; req_write = 2'b00; req_addr0 = 7'd42; rsp_ready = 2'b00;
    #2;
    n_cmp++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rr_accept: got %b want 01", req_ready); end
    @(negedge clock); req_valid = 2'b00;
    @(negedge clock); req_valid = 2'b11; #2;
    n_cmp++; if (rsp_valid !== 2'b01) begin n_fail++; $display("FAIL rr_in_resp: got %b want 01", rsp_valid); end
    reset = 1'b0; #1;
    n_cmp++; if ({rsp_valid, busy, req_ready, mem_en} !== 6'b000000) begin
      n_fail++; $display("FAIL rr_drop: got valid/busy/ready/en %b want 000000", {rsp_valid, busy, req_ready, mem_en});
    end
    @(negedge clock); reset = 1'b1; req_valid = 2'b00;
    do_read(1, 7'd42, 1, 2'b00, 2'b01);
  endtask

  initial begin
    reset = 1'b0; req_valid = 2'b00; req_write = 2'b00; rsp_ready = 2'b00; mem_clr = 1'b1;
    req_addr0 = '0; req_addr1 = '0; req_wdata0 = '0; req_wdata1 = '0;
    for (int i = 0; i < 128; i++) sh_mem[i] = pat(i);
    repeat (2) @(posedge clock);
    test_reset();
    test_write();
    test_read();
    test_arb();
    test_stall();
    test_back_to_back();
    test_reset_in_resp();
    n_cmp++; if (sb.size() != 0) begin n_fail++; $display("FAIL sb_leftover: got %0d entries want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, summary not reached");
    $fatal(1, "watchdog");
  end

endmodule
